writeback_stage_wb: RTL and testbench

Final pipeline stage, consuming the EX-stage result bundle.
- Latches EX results in the WB pipeline latches.
- Sequences the data-cache store handshake and raises WB_Stall back to EX while a store is outstanding.
- Emits single-cycle commit strobes for the GPR, segment and MM register files.
- Holds the architectural EFLAGS register and evaluates REPNE termination for EX.

---
 rtl/writeback_stage_wb.sv | 193 +++++++++++++++++++
 tb/tb_writeback_stage_wb.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage_wb.sv
// Writeback stage: latches EX results, sequences the D-cache store handshake, commits register files, owns EFLAGS.
// Latency: commits fire in the first WB cycle, or one cycle after dcache_wr_ack when the store had to wait.
// Backpressure: WB_Stall holds EX and the WB latches while a store awaits ack; define WB_RETIRE_CNT_EN for retire_count.
module writeback_stage_wb #(
    parameter logic [31:0] FLAGS_RESET = 32'h0000_0002,
    parameter int          MM_W        = 64
) (
    input  logic            CLK,
    input  logic            CLR,
    input  logic            WB_V_next,
    input  logic [31:0]     WB_RESULT_A_next,
    input  logic [31:0]     WB_RESULT_B_next,
    input  logic [31:0]     WB_RESULT_C_next,
    input  logic [31:0]     WB_FLAGS_next,
    input  logic [MM_W-1:0] WB_RESULT_MM_next,
    input  logic            v_ex_ld_gpr1,
    input  logic            v_ex_ld_gpr2,
    input  logic            v_cs_ld_gpr3,
    input  logic            v_cs_ld_seg,
    input  logic            v_cs_ld_mm,
    input  logic            v_ex_dcache_write,
    input  logic            ex_ld_flags,
    input  logic            ex_repne,
    input  logic [31:0]     ex_dcache_addr,
    input  logic [1:0]      ex_datasize,
    input  logic            dcache_wr_ack,
    output logic            WB_Stall,
    output logic            wb_repne_terminate_all,
    output logic            dcache_wr_req,
    output logic [31:0]     dcache_wr_addr,
    output logic [31:0]     dcache_wr_data,
    output logic [1:0]      dcache_wr_size,
    output logic            commit_gpr1,
    output logic            commit_gpr2,
    output logic            commit_gpr3,
    output logic            commit_seg,
    output logic            commit_mm,
    output logic [31:0]     wb_result_a,
    output logic [31:0]     wb_result_b,
    output logic [31:0]     wb_result_c,
    output logic [MM_W-1:0] wb_result_mm,
    output logic [31:0]     flags_dataforwarded,
`ifdef WB_RETIRE_CNT_EN
    output logic [31:0]     count_dataforwarded,
    output logic [31:0]     retire_count
`else
    output logic [31:0]     count_dataforwarded
`endif
);

    typedef struct packed {
        logic            v;
        logic            ld_gpr1;
        logic            ld_gpr2;
        logic            ld_gpr3;
        logic            ld_seg;
        logic            ld_mm;
        logic            dcache_write;
        logic            ld_flags;
        logic            repne;
        logic [31:0]     result_a;
        logic [31:0]     result_b;
        logic [31:0]     result_c;
        logic [31:0]     flags;
        logic [31:0]     addr;
        logic [1:0]      size;
        logic [MM_W-1:0] result_mm;
    } wb_lat_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } st_t;

    wb_lat_t     lat;
    wb_lat_t     lat_d;
    st_t         st;
    st_t         st_nxt;
    logic [31:0] eflags;
    logic        store_pend;
    logic        commit_en;

    always_comb begin
        lat_d              = '0;
        lat_d.v            = WB_V_next;
        lat_d.ld_gpr1      = v_ex_ld_gpr1;
        lat_d.ld_gpr2      = v_ex_ld_gpr2;
        lat_d.ld_gpr3      = v_cs_ld_gpr3;
        lat_d.ld_seg       = v_cs_ld_seg;
        lat_d.ld_mm        = v_cs_ld_mm;
        lat_d.dcache_write = v_ex_dcache_write;
        lat_d.ld_flags     = ex_ld_flags;
        lat_d.repne        = ex_repne;
        lat_d.result_a     = WB_RESULT_A_next;
        lat_d.result_b     = WB_RESULT_B_next;
        lat_d.result_c     = WB_RESULT_C_next;
        lat_d.flags        = WB_FLAGS_next;
        lat_d.addr         = ex_dcache_addr;
        lat_d.size         = ex_datasize;
        lat_d.result_mm    = WB_RESULT_MM_next;
    end

    // The whole latch bundle moves together; a stall freezes it so request fields stay stable.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            lat <= '0;
        end else if (!WB_Stall) begin
            lat <= lat_d;
        end
    end

    assign store_pend = lat.v & lat.dcache_write;

    always_ff @(posedge CLK) begin
        if (CLR) begin
            st <= ST_IDLE;
        end else begin
            st <= st_nxt;
        end
    end

    always_comb begin
        st_nxt = st;
        case (st)
            ST_IDLE: if (store_pend && !dcache_wr_ack) st_nxt = ST_WAIT;
            ST_WAIT: if (dcache_wr_ack) st_nxt = ST_DONE;
            ST_DONE: st_nxt = ST_IDLE;
            default: st_nxt = ST_IDLE;
        endcase
    end

    // An ack in IDLE completes the store in its first cycle, so that instruction never stalls.
    always_comb begin
        dcache_wr_req = 1'b0;
        WB_Stall      = 1'b0;
        case (st)
            ST_IDLE: begin
                dcache_wr_req = store_pend;
                WB_Stall      = store_pend & ~dcache_wr_ack;
            end
            ST_WAIT: begin
                dcache_wr_req = 1'b1;
                WB_Stall      = 1'b1;
            end
            default: begin
                dcache_wr_req = 1'b0;
                WB_Stall      = 1'b0;
            end
        endcase
    end

    assign commit_en   = lat.v & ~WB_Stall;
    assign commit_gpr1 = commit_en & lat.ld_gpr1;
    assign commit_gpr2 = commit_en & lat.ld_gpr2;
    assign commit_gpr3 = commit_en & lat.ld_gpr3;
    assign commit_seg  = commit_en & lat.ld_seg;
    assign commit_mm   = commit_en & lat.ld_mm;

    always_ff @(posedge CLK) begin
        if (CLR) begin
            eflags <= FLAGS_RESET;
        end else if (commit_en && lat.ld_flags) begin
            eflags <= lat.flags;
        end
    end

    // Forwarding deliberately ignores the stall so EX sees the pending flags during a store wait.
    assign flags_dataforwarded = (lat.v & lat.ld_flags) ? lat.flags : eflags;
    assign count_dataforwarded = lat.result_c;

    assign wb_repne_terminate_all = lat.v & lat.repne & ((lat.result_c == 32'd0) | lat.flags[6]);

    assign dcache_wr_addr = lat.addr;
    assign dcache_wr_data = lat.result_b;
    assign dcache_wr_size = lat.size;

    assign wb_result_a  = lat.result_a;
    assign wb_result_b  = lat.result_b;
    assign wb_result_c  = lat.result_c;
    assign wb_result_mm = lat.result_mm;

`ifdef WB_RETIRE_CNT_EN
    always_ff @(posedge CLK) begin
        if (CLR) begin
            retire_count <= 32'd0;
        end else if (commit_en) begin
            retire_count <= retire_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_writeback_stage_wb.sv
// Scoreboard bench for writeback_stage_wb: expectations queued at the EX load edge, checked at commit.
module tb_writeback_stage_wb;

    localparam int MM_W = 64;

    logic            CLK = 1'b0;
    logic            CLR;
    logic            WB_V_next;
    logic [31:0]     WB_RESULT_A_next, WB_RESULT_B_next, WB_RESULT_C_next, WB_FLAGS_next;
    logic [MM_W-1:0] WB_RESULT_MM_next;
    logic            v_ex_ld_gpr1, v_ex_ld_gpr2, v_cs_ld_gpr3, v_cs_ld_seg, v_cs_ld_mm, v_ex_dcache_write;
    logic            ex_ld_flags, ex_repne;
    logic [31:0]     ex_dcache_addr;
    logic [1:0]      ex_datasize;
    logic            dcache_wr_ack;
    logic            WB_Stall, wb_repne_terminate_all, dcache_wr_req;
    logic [31:0]     dcache_wr_addr, dcache_wr_data;
    logic [1:0]      dcache_wr_size;
    logic            commit_gpr1, commit_gpr2, commit_gpr3, commit_seg, commit_mm;
    logic [31:0]     wb_result_a, wb_result_b, wb_result_c;
    logic [MM_W-1:0] wb_result_mm;
    logic [31:0]     flags_dataforwarded, count_dataforwarded;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0]     retire_count;
`endif

    writeback_stage_wb #(.FLAGS_RESET(32'h0000_0002), .MM_W(MM_W)) dut (
        .CLK(CLK), .CLR(CLR), .WB_V_next(WB_V_next),
        .WB_RESULT_A_next(WB_RESULT_A_next), .WB_RESULT_B_next(WB_RESULT_B_next),
        .WB_RESULT_C_next(WB_RESULT_C_next), .WB_FLAGS_next(WB_FLAGS_next),
        .WB_RESULT_MM_next(WB_RESULT_MM_next),
        .v_ex_ld_gpr1(v_ex_ld_gpr1), .v_ex_ld_gpr2(v_ex_ld_gpr2), .v_cs_ld_gpr3(v_cs_ld_gpr3),
        .v_cs_ld_seg(v_cs_ld_seg), .v_cs_ld_mm(v_cs_ld_mm), .v_ex_dcache_write(v_ex_dcache_write),
        .ex_ld_flags(ex_ld_flags), .ex_repne(ex_repne), .ex_dcache_addr(ex_dcache_addr),
        .ex_datasize(ex_datasize), .dcache_wr_ack(dcache_wr_ack),
        .WB_Stall(WB_Stall), .wb_repne_terminate_all(wb_repne_terminate_all),
        .dcache_wr_req(dcache_wr_req), .dcache_wr_addr(dcache_wr_addr),
        .dcache_wr_data(dcache_wr_data), .dcache_wr_size(dcache_wr_size),
        .commit_gpr1(commit_gpr1), .commit_gpr2(commit_gpr2), .commit_gpr3(commit_gpr3),
        .commit_seg(commit_seg), .commit_mm(commit_mm),
        .wb_result_a(wb_result_a), .wb_result_b(wb_result_b), .wb_result_c(wb_result_c),
        .wb_result_mm(wb_result_mm), .flags_dataforwarded(flags_dataforwarded),
`ifdef WB_RETIRE_CNT_EN
        .count_dataforwarded(count_dataforwarded), .retire_count(retire_count)
`else
        .count_dataforwarded(count_dataforwarded)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [4:0]  cmt;   // {mm, seg, gpr3, gpr2, gpr1}
        logic [31:0] a, b, c, flags, addr;
        logic [63:0] mm;
        logic        ldf, rep, st, term;
        int          dly;   // ack arrives on this 0-based request cycle
        logic [1:0]  sz;
    } exp_t;

    exp_t        q[$];
    exp_t        cur;
    logic        ex_v = 1'b0;
    logic        loaded;
    logic        wb_bubble = 1'b1;
    logic        spurious = 1'b0;
    int          wb_delay = 0, req_cyc = 0, stall_cyc = 0, wb_cyc = 0, retire_m = 0;
    logic [31:0] eflags_m = 32'h0000_0002;
    int          n_cmp = 0, n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [4:0] cmt, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] c, input logic [31:0] flags, input logic [63:0] mm,
                                input logic ldf, input logic rep, input logic st, input int dly,
                                input logic [31:0] addr, input logic [1:0] sz);
        exp_t e;
        e.cmt = cmt; e.a = a; e.b = b; e.c = c; e.flags = flags; e.mm = mm;
        e.ldf = ldf; e.rep = rep; e.st = st; e.dly = dly; e.addr = addr; e.sz = sz;
        e.term = rep & ((c == 32'd0) | flags[6]);
        return e;
    endfunction

    task automatic drive_ex(input exp_t e, input logic v);
        WB_V_next = v;
        WB_RESULT_A_next = e.a; WB_RESULT_B_next = e.b; WB_RESULT_C_next = e.c;
        WB_FLAGS_next = e.flags; WB_RESULT_MM_next = e.mm;
        v_ex_ld_gpr1 = e.cmt[0]; v_ex_ld_gpr2 = e.cmt[1]; v_cs_ld_gpr3 = e.cmt[2];
        v_cs_ld_seg = e.cmt[3]; v_cs_ld_mm = e.cmt[4]; v_ex_dcache_write = e.st;
        ex_ld_flags = e.ldf; ex_repne = e.rep; ex_dcache_addr = e.addr; ex_datasize = e.sz;
    endtask

    // One clock: respond to the request, check the WB slot, then track the load edge.
    task automatic step();
        logic       stall_s;
        logic [4:0] cv;
        exp_t       e;
        @(negedge CLK);
        if (dcache_wr_req) begin
            dcache_wr_ack = (req_cyc == wb_delay);
            req_cyc++;
        end else begin
            dcache_wr_ack = spurious;
        end
        #1;
        wb_cyc++;
        stall_s = WB_Stall;
        if (stall_s) stall_cyc++;
        cv = {commit_mm, commit_seg, commit_gpr3, commit_gpr2, commit_gpr1};
        if (wb_bubble) begin
            chk("bubble_commit", cv, 5'd0);
            chk("bubble_req", dcache_wr_req, 1'b0);
            chk("bubble_stall", stall_s, 1'b0);
            chk("bubble_term", wb_repne_terminate_all, 1'b0);
        end
        if (dcache_wr_req && q.size() != 0) begin
            chk("st_addr", dcache_wr_addr, q[0].addr);
            chk("st_data", dcache_wr_data, q[0].b);
            chk("st_size", dcache_wr_size, q[0].sz);
        end
        if (cv != 5'd0) begin
            chk("sb_nonempty", q.size() != 0, 1'b1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("commit_vec", cv, e.cmt);
                chk("res_a", wb_result_a, e.a);
                chk("res_b", wb_result_b, e.b);
                chk("res_c", wb_result_c, e.c);
                chk("count_fwd", count_dataforwarded, e.c);
                chk("res_mm", wb_result_mm, e.mm);
                chk("flags_fwd", flags_dataforwarded, e.ldf ? e.flags : eflags_m);
                chk("terminate", wb_repne_terminate_all, e.term);
                chk("stall_cycles", stall_cyc, (e.st && e.dly > 0) ? e.dly + 1 : 0);
                chk("req_cycles", req_cyc, e.st ? e.dly + 1 : 0);
                chk("wb_latency", wb_cyc, (e.st && e.dly > 0) ? e.dly + 2 : 1);
                if (e.ldf) eflags_m = e.flags;
                retire_m++;
            end
        end
        @(posedge CLK);
        if (!stall_s) begin
            if (ex_v) q.push_back(cur);
            wb_bubble = !ex_v;
            wb_delay  = ex_v ? cur.dly : 0;
            req_cyc = 0; stall_cyc = 0; wb_cyc = 0;
            loaded = 1'b1;
        end
        #1;
        dcache_wr_ack = 1'b0;
    endtask

    task automatic issue(input exp_t e);
        cur = e; ex_v = 1'b1; loaded = 1'b0;
        drive_ex(e, 1'b1);
        for (int k = 0; k < 200 && !loaded; k++) step();
        chk("load_timeout", loaded, 1'b1);
        ex_v = 1'b0;
        WB_V_next = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        CLR = 1'b1; dcache_wr_ack = 1'b0;
        drive_ex(mk(5'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0), 1'b0);
        repeat (2) @(posedge CLK);
        #1 CLR = 1'b0;
        @(negedge CLK); #1;
        chk("rst_req", dcache_wr_req, 1'b0);
        chk("rst_stall", WB_Stall, 1'b0);
        chk("rst_commit", {commit_mm, commit_seg, commit_gpr3, commit_gpr2, commit_gpr1}, 5'd0);
        chk("rst_term", wb_repne_terminate_all, 1'b0);
        chk("rst_flags", flags_dataforwarded, 32'h0000_0002);
        chk("rst_res_a", wb_result_a, 32'd0);
        @(posedge CLK); #1;

        issue(mk(5'b00001, 32'h1234_5678, 32'h0, 32'h0, 32'h0, 64'h0, 0, 0, 0, 0, 32'h0, 2'd0));
        spurious = 1'b1;
        issue(mk(5'b00010, 32'hA5A5_0001, 32'h0, 32'h7, 32'h0000_0893, 64'h0, 1, 0, 0, 0, 32'h0, 2'd0));
        issue(mk(5'b01000, 32'h0000_0023, 32'h0, 32'h0, 32'hFFFF_FFFF, 64'h0, 0, 0, 0, 0, 32'h0, 2'd0));
        drain(2);
        spurious = 1'b0;
        issue(mk(5'b00100, 32'h0, 32'hDEAD_BEEF, 32'h0000_0FFC, 32'h0, 64'h0, 0, 0, 1, 2, 32'h1000_0040, 2'd2));
        issue(mk(5'b00001, 32'h0BAD_F00D, 32'h0, 32'h0, 32'h0, 64'h0, 0, 0, 0, 0, 32'h0, 2'd0));
        issue(mk(5'b00100, 32'h0, 32'h0000_00AB, 32'h0000_0FF8, 32'h0, 64'h0, 0, 0, 1, 0, 32'h1000_0003, 2'd0));
        drain(3);
        issue(mk(5'b00100, 32'h0, 32'h0, 32'h0, 32'h0000_0002, 64'h0, 0, 1, 0, 0, 32'h0, 2'd0));
        issue(mk(5'b00100, 32'h0, 32'h0, 32'h5, 32'h0000_0042, 64'h0, 0, 1, 0, 0, 32'h0, 2'd0));
        issue(mk(5'b00100, 32'h0, 32'h0, 32'h5, 32'h0000_0002, 64'h0, 0, 1, 0, 0, 32'h0, 2'd0));
        issue(mk(5'b00100, 32'h0, 32'h0, 32'h0, 32'h0000_0002, 64'h0, 0, 0, 0, 0, 32'h0, 2'd0));
        issue(mk(5'b10000, 32'h0, 32'h0, 32'h0, 32'h0, 64'hFEDC_BA98_7654_3210, 0, 0, 0, 0, 32'h0, 2'd0));
        issue(mk(5'b00100, 32'h0, 32'hCAFE_1234, 32'h0000_0FF4, 32'h0000_0046, 64'h0, 1, 0, 1, 1, 32'h2000_0010, 2'd1));
        drain(4);

        // Reset while a store sits in WAIT, with an ack landing on the reset edge.
        issue(mk(5'b00100, 32'h0, 32'h5555_AAAA, 32'h0000_0100, 32'h0000_08D7, 64'h0, 1, 0, 1, 1000, 32'h3000_0000, 2'd2));
        step(); step();
        CLR = 1'b1;
        @(negedge CLK); dcache_wr_ack = 1'b1;
        @(posedge CLK); #1 CLR = 1'b0; dcache_wr_ack = 1'b0;
        @(negedge CLK); #1;
        chk("clr_req", dcache_wr_req, 1'b0);
        chk("clr_stall", WB_Stall, 1'b0);
        chk("clr_flags", flags_dataforwarded, 32'h0000_0002);
        chk("clr_commit", {commit_mm, commit_seg, commit_gpr3, commit_gpr2, commit_gpr1}, 5'd0);
        chk("clr_term", wb_repne_terminate_all, 1'b0);
        q.delete();
        wb_bubble = 1'b1; req_cyc = 0; stall_cyc = 0; wb_cyc = 0;
        eflags_m = 32'h0000_0002; retire_m = 0;
        @(posedge CLK); #1;

        issue(mk(5'b00001, 32'h0000_0011, 32'h0, 32'h0, 32'h0, 64'h0, 0, 0, 0, 0, 32'h0, 2'd0));
        issue(mk(5'b00100, 32'h0, 32'h0000_BEEF, 32'h0000_0FFE, 32'h0, 64'h0, 0, 0, 1, 1, 32'h4000_0002, 2'd1));
        issue(mk(5'b00010, 32'h0000_0022, 32'h0, 32'h0, 32'h0, 64'h0, 0, 0, 0, 0, 32'h0, 2'd0));
        issue(mk(5'b01000, 32'h0000_0033, 32'h0, 32'h0, 32'h0, 64'h0, 0, 0, 0, 0, 32'h0, 2'd0));
        drain(5);
`ifdef WB_RETIRE_CNT_EN
        chk("retire_count", retire_count, retire_m);
`endif
        chk("sb_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
